dmem_stage: RTL and testbench

- MEM-stage data memory unit. Executes one RISC-V load or store per request over the AXI master read and write channels.
- Holds the pipeline via stall until the access completes.
- Consumes the EX/MEM register outputs: address from the ALU result, store data, funct3. Produces the load result for the WB register.

---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/dmem_align.sv | 54 +++++
 rtl/dmem_stage.sv | 189 ++++++++++++++++++
 tb/tb_dmem_stage.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory unit.
// Holds the FSM state encoding, RISC-V funct3 size/sign codes and the AXI field values.
// No logic; only a helper that turns a funct3 size code into a byte count.
package dmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } dmem_state_t;

    typedef logic [2:0] mem_funct3_t;

    // Loads: low two bits give the size, bit 2 selects zero extension.
    localparam mem_funct3_t F3_LB  = 3'd0;
    localparam mem_funct3_t F3_LH  = 3'd1;
    localparam mem_funct3_t F3_LW  = 3'd2;
    localparam mem_funct3_t F3_LD  = 3'd3;
    localparam mem_funct3_t F3_LBU = 3'd4;
    localparam mem_funct3_t F3_LHU = 3'd5;
    localparam mem_funct3_t F3_LWU = 3'd6;

    // Stores: only the size codes exist.
    localparam mem_funct3_t F3_SB  = 3'd0;
    localparam mem_funct3_t F3_SH  = 3'd1;
    localparam mem_funct3_t F3_SW  = 3'd2;
    localparam mem_funct3_t F3_SD  = 3'd3;

    // Every access is one full 8-byte beat.
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'b011;

    // Access size in bytes (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input logic [1:0] size_code);
        return 4'd1 << size_code;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane alignment for one 64-bit beat: load extraction, store shift, strobes, misalign.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  offset,
    input  logic [63:0] rdata,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] wdata_aligned,
    output logic [7:0]  wstrb,
    output logic        misalign
);

    logic [3:0]  size;
    logic [63:0] shifted;
    logic [7:0]  strb_base;

    assign size          = size_bytes(funct3[1:0]);
    assign misalign      = (({1'b0, offset} & (size - 4'd1)) != 4'd0);
    assign shifted       = rdata >> {offset, 3'b000};
    assign wdata_aligned = wdata << {offset, 3'b000};
    assign wstrb         = strb_base << offset;

    // Pick the addressed field out of the shifted beat and extend it.
    always_comb begin
        load_data = '0;
        case (funct3)
            F3_LB:   load_data = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   load_data = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   load_data = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   load_data = shifted;
            F3_LBU:  load_data = {56'd0, shifted[7:0]};
            F3_LHU:  load_data = {48'd0, shifted[15:0]};
            F3_LWU:  load_data = {32'd0, shifted[31:0]};
            default: load_data = '0;
        endcase
    end

    // Strobe pattern for the access size before moving it to the byte offset.
    always_comb begin
        strb_base = 8'h00;
        case ({1'b0, funct3[1:0]})
            F3_SB:   strb_base = 8'h01;
            F3_SH:   strb_base = 8'h03;
            F3_SW:   strb_base = 8'h0F;
            F3_SD:   strb_base = 8'hFF;
            default: strb_base = 8'h00;
        endcase
    end

endmodule

// File: rtl/dmem_stage.sv
// MEM-stage data memory unit: one RISC-V load/store per request as a single-beat AXI transaction.
// Latency: 3 cycles minimum for loads and stores (request to resp_valid); 1 cycle for rejected requests.
// Backpressure: stall holds the pipeline until the DONE cycle; AXI valids wait on their readies.
module dmem_stage
    import dmem_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int AXI_ID     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_load,
    input  logic                    req_store,
    input  logic [2:0]              req_funct3,
    input  logic [63:0]             req_addr,
    input  logic [63:0]             req_wdata,
    output logic                    stall,
    output logic                    resp_valid,
    output logic [63:0]             resp_data,
    output logic                    resp_err,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    localparam logic [ID_WIDTH-1:0] ID_VAL = ID_WIDTH'(AXI_ID);

    dmem_state_t state;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;
    logic [2:0]  lat_funct3;
    logic        aw_done;
    logic        w_done;

    logic        req_fire;
    logic        req_err;
    logic [2:0]  al_funct3;
    logic [2:0]  al_offset;
    logic [63:0] load_data;
    logic [63:0] wdata_aligned;
    logic [7:0]  wstrb;
    logic        misalign;
    logic        unused_sigs;

    // Only one transaction is ever outstanding, so the returned IDs and rlast carry no information.
    assign unused_sigs = ^{m_axi_rid, m_axi_bid, m_axi_rlast};

    assign req_fire = req_valid & (req_load | req_store);
    assign stall    = req_fire & (state != ST_DONE);

    // In IDLE the aligner checks the incoming request; afterwards it works on the latched copy.
    assign al_funct3 = (state == ST_IDLE) ? req_funct3    : lat_funct3;
    assign al_offset = (state == ST_IDLE) ? req_addr[2:0] : lat_addr[2:0];

    assign req_err = misalign | (req_funct3 == 3'd7) | (req_store & req_funct3[2]) | (req_load & req_store);

    dmem_align u_align (
        .funct3        (al_funct3),
        .offset        (al_offset),
        .rdata         (m_axi_rdata),
        .wdata         (lat_wdata),
        .load_data     (load_data),
        .wdata_aligned (wdata_aligned),
        .wstrb         (wstrb),
        .misalign      (misalign)
    );

    assign resp_valid    = (state == ST_DONE);

    assign m_axi_arid    = ID_VAL;
    assign m_axi_araddr  = ADDR_WIDTH'({lat_addr[63:3], 3'b000});
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = SIZE_8B;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arvalid = (state == ST_RD_ADDR);
    assign m_axi_rready  = (state == ST_RD_DATA);

    assign m_axi_awid    = ID_VAL;
    assign m_axi_awaddr  = ADDR_WIDTH'({lat_addr[63:3], 3'b000});
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = SIZE_8B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awvalid = (state == ST_WR_REQ) & ~aw_done;
    assign m_axi_wdata   = wdata_aligned;
    assign m_axi_wstrb   = wstrb;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wvalid  = (state == ST_WR_REQ) & ~w_done;
    assign m_axi_bready  = (state == ST_WR_RESP);

    // Access sequencer: accept in IDLE, run the AXI handshakes, report for exactly one DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        lat_funct3 <= req_funct3;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        resp_data  <= '0;
                        resp_err   <= req_err;
                        if (req_err) begin
                            state <= ST_DONE;
                        end else if (req_load) begin
                            state <= ST_RD_ADDR;
                        end else begin
                            state <= ST_WR_REQ;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (m_axi_arready) begin
                        state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        resp_err  <= (m_axi_rresp != 2'b00);
                        resp_data <= (m_axi_rresp == 2'b00) ? load_data : '0;
                        state     <= ST_DONE;
                    end
                end
                ST_WR_REQ: begin
                    if (m_axi_awready) begin
                        aw_done <= 1'b1;
                    end
                    if (m_axi_wready) begin
                        w_done <= 1'b1;
                    end
                    if ((aw_done | m_axi_awready) & (w_done | m_axi_wready)) begin
                        state <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        resp_err <= (m_axi_bresp != 2'b00);
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_stage.sv
// Self-checking bench for dmem_stage: directed vector table, reset corner cases, randomized traffic.
// Expected results come from hand-computed vectors or a byte-arithmetic reference model.
// A cycle-level AXI slave model with per-channel delays drives the bus side.
module tb_dmem_stage;

    logic        clk;
    logic        reset;
    logic        req_valid, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        stall, resp_valid, resp_err;
    logic [63:0] resp_data;
    logic [12:0] m_axi_arid, m_axi_rid, m_axi_awid, m_axi_bid;
    logic [63:0] m_axi_araddr, m_axi_awaddr, m_axi_rdata, m_axi_wdata;
    logic [7:0]  m_axi_arlen, m_axi_awlen, m_axi_wstrb;
    logic [2:0]  m_axi_arsize, m_axi_awsize;
    logic [1:0]  m_axi_arburst, m_axi_awburst, m_axi_rresp, m_axi_bresp;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_stage #(.ID_WIDTH(13), .ADDR_WIDTH(64), .DATA_WIDTH(64), .AXI_ID(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = rejected at request (no bus traffic), 1 = read transaction, 2 = write transaction
    typedef struct {
        bit          load;
        bit          store;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic [1:0]  bresp;
        int          ard, rd, awd, wd, bd;
        int          kind;
        bit          err;
        logic [63:0] data;
        logic [63:0] wdat;
        logic [7:0]  strb;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(bit l, bit s, logic [2:0] f, logic [63:0] a, logic [63:0] wd,
                                logic [63:0] rdt, logic [1:0] rr, logic [1:0] br,
                                int dar, int dr, int daw, int dw, int db,
                                int k, bit e, logic [63:0] dat, logic [63:0] wdt, logic [7:0] st);
        vec_t v;
        v.load = l; v.store = s; v.f3 = f; v.addr = a; v.wdata = wd; v.rdata = rdt;
        v.rresp = rr; v.bresp = br; v.ard = dar; v.rd = dr; v.awd = daw; v.wd = dw; v.bd = db;
        v.kind = k; v.err = e; v.data = dat; v.wdat = wdt; v.strb = st;
        return v;
    endfunction

    // Reference model: size, alignment and extension computed with plain integer arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int sz = 1 << (int'(v.f3) % 4);
        int off = int'(v.addr % 64'd8);
        longint unsigned val;
        r.data = 0; r.wdat = 0; r.strb = 0; r.err = 0;
        if ((v.load && v.store) || v.f3 == 3'd7 || (v.store && v.f3 >= 3'd4) || (off % sz) != 0) begin
            r.kind = 0;
            r.err  = 1;
        end else if (v.load) begin
            r.kind = 1;
            if (v.rresp != 2'd0) begin
                r.err = 1;
            end else begin
                val = v.rdata >> (8 * off);
                if (sz < 8) begin
                    val = val % (64'd1 << (8 * sz));
                    if (v.f3 < 3'd4 && val >= (64'd1 << (8 * sz - 1)))
                        val = val - (64'd1 << (8 * sz));
                end
                r.data = val;
            end
        end else begin
            r.kind = 2;
            r.err  = (v.bresp != 2'd0);
            r.wdat = v.wdata << (8 * off);
            for (int i = 0; i < 8; i++)
                if (i >= off && i < off + sz) r.strb[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic int exp_lat(input vec_t v);
        if (v.kind == 0) return 1;
        if (v.kind == 1) return 3 + v.ard + v.rd;
        return 3 + ((v.awd > v.wd) ? v.awd : v.wd) + v.bd;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_slave();
        m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0;
        m_axi_rvalid = 0; m_axi_bvalid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; req_valid = 0; req_load = 0; req_store = 0;
        clear_slave();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    // Issue one request, play the AXI slave cycle by cycle, then check everything observed.
    task automatic run_txn(input vec_t v, input string tag);
        int c = 0, lat = -1, elat, n_ar = 0, n_aw = 0, n_w = 0, n_vld = 0, late = 0;
        int ar_w = 0, aw_w = 0, w_w = 0, ar_cyc = 0, aw_cyc = 0, w_cyc = 0;
        bit ar_hs = 0, aw_hs = 0, w_hs = 0, r_done = 0, b_done = 0, stall_ok = 1;
        logic [63:0] g_data = 0, g_araddr = 0, g_awaddr = 0, g_wdat = 0;
        logic [7:0]  g_strb = 0;
        logic        g_err = 0, g_wlast = 0;
        logic [25:0] g_arf = 0, g_awf = 0;
        elat = exp_lat(v);
        req_valid = 1; req_load = v.load; req_store = v.store;
        req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        m_axi_rdata = v.rdata; m_axi_rresp = v.rresp; m_axi_bresp = v.bresp;
        m_axi_rlast = 1; m_axi_rid = 13'd1; m_axi_bid = 13'd1;
        while (lat < 0 && c < 64) begin
            #1;
            if (stall !== (c < elat)) stall_ok = 0;
            if (resp_valid) begin
                lat = c; g_data = resp_data; g_err = resp_err;
            end
            if (m_axi_arvalid || m_axi_awvalid || m_axi_wvalid) n_vld++;
            clear_slave();
            if (m_axi_arvalid) begin
                if (ar_hs) late++;
                else begin
                    m_axi_arready = (ar_w >= v.ard); ar_w++;
                    if (m_axi_arready) begin
                        ar_hs = 1; ar_cyc = c; n_ar++; g_araddr = m_axi_araddr;
                        g_arf = {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst};
                    end
                end
            end
            if (ar_hs && !r_done && c >= ar_cyc + 1 + v.rd) begin
                m_axi_rvalid = 1;
                if (m_axi_rready) r_done = 1;
            end
            if (m_axi_awvalid) begin
                if (aw_hs) late++;
                else begin
                    m_axi_awready = (aw_w >= v.awd); aw_w++;
                    if (m_axi_awready) begin
                        aw_hs = 1; aw_cyc = c; n_aw++; g_awaddr = m_axi_awaddr;
                        g_awf = {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst};
                    end
                end
            end
            if (m_axi_wvalid) begin
                if (w_hs) late++;
                else begin
                    m_axi_wready = (w_w >= v.wd); w_w++;
                    if (m_axi_wready) begin
                        w_hs = 1; w_cyc = c; n_w++;
                        g_wdat = m_axi_wdata; g_strb = m_axi_wstrb; g_wlast = m_axi_wlast;
                    end
                end
            end
            if (aw_hs && w_hs && !b_done && c >= ((aw_cyc > w_cyc) ? aw_cyc : w_cyc) + 1 + v.bd) begin
                m_axi_bvalid = 1;
                if (m_axi_bready) b_done = 1;
            end
            @(negedge clk);
            c++;
        end
        req_valid = 0;
        clear_slave();
        #1;
        check({tag, ".one_pulse"}, 64'(resp_valid), 64'd0);
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        check({tag, ".err"}, 64'(g_err), 64'(v.err));
        check({tag, ".data"}, g_data, v.data);
        check({tag, ".stall"}, 64'(stall_ok), 64'd1);
        check({tag, ".valid_after_hs"}, 64'(late), 64'd0);
        if (v.kind == 0) begin
            check({tag, ".no_axi"}, 64'(n_vld), 64'd0);
        end else if (v.kind == 1) begin
            check({tag, ".ar_cnt"}, 64'(n_ar), 64'd1);
            check({tag, ".w_cnt"}, 64'(n_aw + n_w), 64'd0);
            check({tag, ".araddr"}, g_araddr, v.addr - (v.addr % 64'd8));
            check({tag, ".ar_fields"}, 64'(g_arf), 64'({13'd1, 8'd0, 3'd3, 2'd1}));
        end else begin
            check({tag, ".aw_cnt"}, 64'(n_aw), 64'd1);
            check({tag, ".wd_cnt"}, 64'(n_w), 64'd1);
            check({tag, ".ar_cnt"}, 64'(n_ar), 64'd0);
            check({tag, ".awaddr"}, g_awaddr, v.addr - (v.addr % 64'd8));
            check({tag, ".aw_fields"}, 64'(g_awf), 64'({13'd1, 8'd0, 3'd3, 2'd1}));
            check({tag, ".wdata"}, g_wdat, v.wdat);
            check({tag, ".wstrb"}, 64'(g_strb), 64'(v.strb));
            check({tag, ".wlast"}, 64'(g_wlast), 64'd1);
        end
        if (lat < 0) do_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int spur;
        //            l  s  f3    addr          wdata                  rdata                  rr    br    ar r aw w b  k  e  data                   wdat                   strb
        tbl[0]  = mk(1, 0, 3'd3, 64'h1000, 64'h0,                 64'h1122334455667788, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 64'h1122334455667788, 64'h0, 8'h00);
        tbl[1]  = mk(1, 0, 3'd0, 64'h1003, 64'h0,                 64'h00000000F0000000, 2'd0, 2'd0, 1, 1, 0, 0, 0, 1, 0, 64'hFFFFFFFFFFFFFFF0, 64'h0, 8'h00);
        tbl[2]  = mk(1, 0, 3'd4, 64'h1003, 64'h0,                 64'h00000000F0000000, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 64'h00000000000000F0, 64'h0, 8'h00);
        tbl[3]  = mk(0, 1, 3'd1, 64'h2006, 64'hABCD,              64'h0,                2'd0, 2'd0, 0, 0, 0, 0, 0, 2, 0, 64'h0, 64'hABCD000000000000, 8'hC0);
        tbl[4]  = mk(0, 1, 3'd1, 64'h2006, 64'hABCD,              64'h0,                2'd0, 2'd0, 0, 0, 0, 2, 1, 2, 0, 64'h0, 64'hABCD000000000000, 8'hC0);
        tbl[5]  = mk(0, 1, 3'd2, 64'h2006, 64'h1234,              64'h0,                2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 64'h0, 8'h00);
        tbl[6]  = mk(1, 0, 3'd2, 64'h3004, 64'h0,                 64'h5555555555555555, 2'd2, 2'd0, 0, 1, 0, 0, 0, 1, 1, 64'h0, 64'h0, 8'h00);
        tbl[7]  = mk(1, 0, 3'd1, 64'h100A, 64'h0,                 64'h123456789ABCDEF0, 2'd0, 2'd0, 2, 0, 0, 0, 0, 1, 0, 64'hFFFFFFFFFFFF9ABC, 64'h0, 8'h00);
        tbl[8]  = mk(1, 0, 3'd6, 64'h1004, 64'h0,                 64'h89ABCDEF00000000, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 64'h0000000089ABCDEF, 64'h0, 8'h00);
        tbl[9]  = mk(1, 0, 3'd2, 64'h1004, 64'h0,                 64'h89ABCDEF00000000, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 64'hFFFFFFFF89ABCDEF, 64'h0, 8'h00);
        tbl[10] = mk(0, 1, 3'd3, 64'h4000, 64'hDEADBEEFCAFEF00D,  64'h0,                2'd0, 2'd0, 0, 0, 2, 0, 0, 2, 0, 64'h0, 64'hDEADBEEFCAFEF00D, 8'hFF);
        tbl[11] = mk(0, 1, 3'd0, 64'h4005, 64'h000000123456789A,  64'h0,                2'd0, 2'd0, 0, 0, 1, 1, 2, 2, 0, 64'h0, 64'h56789A0000000000, 8'h20);
        tbl[12] = mk(1, 0, 3'd7, 64'h1000, 64'h0,                 64'h0,                2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 64'h0, 8'h00);
        tbl[13] = mk(0, 1, 3'd4, 64'h1000, 64'h55,                64'h0,                2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 64'h0, 8'h00);
        tbl[14] = mk(1, 1, 3'd3, 64'h1000, 64'h0,                 64'h0,                2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 64'h0, 8'h00);
        tbl[15] = mk(1, 0, 3'd3, 64'h1004, 64'h0,                 64'h0,                2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 64'h0, 8'h00);
        tbl[16] = mk(0, 1, 3'd0, 64'h4001, 64'h77,                64'h0,                2'd0, 2'd2, 0, 0, 0, 0, 0, 2, 1, 64'h0, 64'h7700, 8'h02);
        tbl[17] = mk(1, 0, 3'd5, 64'h1006, 64'h0,                 64'h8001000000000000, 2'd0, 2'd0, 3, 2, 0, 0, 0, 1, 0, 64'h0000000000008001, 64'h0, 8'h00);
        tbl[18] = mk(1, 0, 3'd0, 64'h1007, 64'h0,                 64'h7F00000000000000, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 64'h000000000000007F, 64'h0, 8'h00);

        reset = 1; req_valid = 0; req_load = 0; req_store = 0; req_funct3 = 0;
        req_addr = 0; req_wdata = 0;
        m_axi_rdata = 0; m_axi_rresp = 0; m_axi_bresp = 0; m_axi_rlast = 0;
        m_axi_rid = 0; m_axi_bid = 0;
        clear_slave();
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        check("reset.valids", 64'({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, resp_valid}), 64'd0);
        check("reset.stall", 64'(stall), 64'd0);
        check("reset.resp_data", resp_data, 64'd0);
        check("reset.resp_err", 64'(resp_err), 64'd0);
        @(negedge clk);

        for (int i = 0; i < 19; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting for read data: abort to idle, then ignore stray responses.
        @(negedge clk);
        req_valid = 1; req_load = 1; req_store = 0; req_funct3 = 3'd3; req_addr = 64'h5000;
        @(negedge clk);
        #1;
        check("rst_mid.arvalid", 64'(m_axi_arvalid), 64'd1);
        m_axi_arready = 1;
        @(negedge clk);
        m_axi_arready = 0;
        #1;
        check("rst_mid.rready", 64'(m_axi_rready), 64'd1);
        reset = 1; req_valid = 0;
        @(negedge clk);
        #1;
        check("rst_mid.valids", 64'({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, resp_valid}), 64'd0);
        check("rst_mid.resp_err", 64'(resp_err), 64'd0);
        check("rst_mid.resp_data", resp_data, 64'd0);
        check("rst_mid.stall", 64'(stall), 64'd0);
        reset = 0; m_axi_rvalid = 1; m_axi_bvalid = 1; m_axi_rresp = 0; m_axi_bresp = 0;
        spur = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (resp_valid || m_axi_rready || m_axi_bready || m_axi_arvalid || m_axi_awvalid) spur++;
        end
        check("stray_resp.ignored", 64'(spur), 64'd0);
        clear_slave();
        @(negedge clk);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            int roll;
            roll = $urandom_range(0, 99);
            v.load  = (roll < 50);
            v.store = (roll >= 46);
            if ($urandom_range(0, 9) == 0) v.f3 = 3'($urandom_range(0, 7));
            else if (v.load)               v.f3 = 3'($urandom_range(0, 6));
            else                           v.f3 = 3'($urandom_range(0, 3));
            v.addr = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) v.addr = v.addr - (v.addr % (64'd1 << v.f3[1:0]));
            v.wdata = {$urandom(), $urandom()};
            v.rdata = {$urandom(), $urandom()};
            v.rresp = ($urandom_range(0, 9) == 0) ? 2'd2 : 2'd0;
            v.bresp = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'd0;
            v.ard = $urandom_range(0, 3); v.rd = $urandom_range(0, 3);
            v.awd = $urandom_range(0, 3); v.wd = $urandom_range(0, 3); v.bd = $urandom_range(0, 3);
            v = model(v);
            run_txn(v, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
